// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, defaults and sizing helpers for the parametrised FIFO.
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AE_THRESH  = 2;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy flags, overflow/underflow pulses,
// synchronous flush and optional first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        rvalid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] fifo_counter,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AF_THRESH > DEPTH) || (AE_THRESH >= DEPTH)) begin : g_param_err
    $error("sync_fifo_param: DEPTH must be a power of 2 >= 4, AF_THRESH <= DEPTH, AE_THRESH < DEPTH");
  end

  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid, r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc, w_we;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign full         = r_count == CW'(DEPTH);
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= CW'(AF_THRESH);
  assign almost_empty = r_count <= CW'(AE_THRESH);
  assign fifo_counter = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign w_wr_acc     = wr_en & ~full;
  assign w_rd_acc     = rd_en & ~empty;
  // Reset and flush both suppress the memory write so no stale entry lands in the array
  assign w_we         = w_wr_acc & ~flush & ~rst;
  assign rdata        = (MODE == FIFO_FWFT) ? w_mem_rdata : r_rdata;
  assign rvalid       = (MODE == FIFO_FWFT) ? ~empty : r_rvalid;

  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_acc) r_rdata <= w_mem_rdata;
      r_count     <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      r_rvalid    <= w_rd_acc;
      r_overflow  <= wr_en & full;
      r_underflow <= rd_en & empty;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model scoreboard for standard and FWFT FIFO instances.
`define CHK(name, act, exp) begin n_vec++; if ((act) !== (exp)) begin n_err++; $display("FAIL %s: got %0h want %0h", name, act, exp); end end

module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  logic       clk = 1'b0, rst = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata_s, rdata_f;
  logic       rvalid_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic       rvalid_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] cnt_s, cnt_f;
  int         n_vec = 0, n_err = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_std = '0;
  bit         e_ovf = 0, e_unf = 0, e_rv = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata_s), .rvalid(rvalid_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .fifo_counter(cnt_s), .overflow(ovf_s), .underflow(unf_s));

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata_f), .rvalid(rvalid_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .fifo_counter(cnt_f), .overflow(ovf_f), .underflow(unf_f));

  task automatic check_all();
    int m = mq.size();
    `CHK("count_s", cnt_s, 5'(m))
    `CHK("count_f", cnt_f, 5'(m))
    `CHK("full_s", full_s, m == DEPTH)
    `CHK("full_f", full_f, m == DEPTH)
    `CHK("empty_s", empty_s, m == 0)
    `CHK("empty_f", empty_f, m == 0)
    `CHK("afull_s", af_s, m >= DEPTH - 2)
    `CHK("afull_f", af_f, m >= DEPTH - 2)
    `CHK("aempty_s", ae_s, m <= 2)
    `CHK("aempty_f", ae_f, m <= 2)
    `CHK("ovf_s", ovf_s, e_ovf)
    `CHK("ovf_f", ovf_f, e_ovf)
    `CHK("unf_s", unf_s, e_unf)
    `CHK("unf_f", unf_f, e_unf)
    `CHK("rvalid_s", rvalid_s, e_rv)
    `CHK("rdata_hold_s", rdata_s, last_std)
    `CHK("rvalid_f", rvalid_f, m != 0)
    if (m != 0) `CHK("rdata_f", rdata_f, mq[0])
  endtask

  task automatic step(input bit wr, input bit rd, input bit fl, input logic [7:0] d);
    bit wacc, racc;
    @(negedge clk);
    wr_en = wr; rd_en = rd; flush = fl; wdata = d;
    wacc = wr && (mq.size() < DEPTH);
    racc = rd && (mq.size() != 0);
    if (fl) begin
      mq.delete();
      e_ovf = 0; e_unf = 0; e_rv = 0;
    end else begin
      if (racc) begin
        last_std = mq.pop_front();
        exp_q.push_back(last_std);
      end
      if (wacc) mq.push_back(d);
      e_ovf = wr && !wacc;
      e_unf = rd && !racc;
      e_rv  = racc;
    end
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    last_std = '0; e_ovf = 0; e_unf = 0; e_rv = 0;
  endtask

  // Standard-mode read data is checked against the order reads were accepted
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rvalid_s === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_rdata: got %0h with rvalid but want no read", rdata_s);
        end else begin
          e = exp_q.pop_front();
          `CHK("sb_rdata", rdata_s, e)
        end
      end
    end
  end

  initial begin
    int pw, pr;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    #1 check_all();
    for (int i = 0; i < 17; i++) step(1, 0, 0, 8'(i));
    for (int i = 0; i < 17; i++) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 12; i++) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'($urandom));
    step(1, 1, 0, 8'hEE);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h3C);
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h50 + i));
    step(1, 0, 1, 8'h77);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(1, i[0], 0, 8'(8'hC0 + i));
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; wdata = 8'hDD;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    #1 check_all();
    for (int i = 0; i < 600; i++) begin
      pw = (i < 150) ? 75 : (i < 300) ? 30 : (i < 450) ? 55 : 90;
      pr = (i < 150) ? 35 : (i < 300) ? 75 : (i < 450) ? 55 : 20;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, $urandom_range(0, 59) == 0, 8'($urandom));
    end
    for (int i = 0; i < 17; i++) step(0, 1, 0, 8'h00);
    @(posedge clk);
    #3;
    `CHK("sb_drained", exp_q.size(), 0)
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
